// File: rtl/tikhonov_pkg.sv
// Shared types and helpers for the regularized Gram matrix stage: state encoding,
// accumulator sizing and output saturation.
package tikhonov_pkg;

   localparam int PKG_DATA_WIDTH = 24;
   localparam int PKG_MIC_NUM    = 8;
   localparam int PKG_SOR_NUM    = 2;
   localparam int PAIR_NUM       = PKG_SOR_NUM * (PKG_SOR_NUM + 1) / 2;
   localparam int ACC_WIDTH      = 2 * PKG_DATA_WIDTH + $clog2(PKG_MIC_NUM) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MAC  = 3'd2,
      S_WR   = 3'd3,
      S_WRT  = 3'd4,
      S_NEXT = 3'd5,
      S_DONE = 3'd6
   } state_t;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-PKG_DATA_WIDTH+1){1'b0}}, {(PKG_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-PKG_DATA_WIDTH+1){1'b1}}, {(PKG_DATA_WIDTH-1){1'b0}}};

   function automatic logic signed [PKG_DATA_WIDTH-1:0] saturate(
      input logic signed [ACC_WIDTH-1:0] x
   );
      logic signed [PKG_DATA_WIDTH-1:0] y;
      if (x > SAT_MAX) begin
         y = SAT_MAX[PKG_DATA_WIDTH-1:0];
      end else if (x < SAT_MIN) begin
         y = SAT_MIN[PKG_DATA_WIDTH-1:0];
      end else begin
         y = x[PKG_DATA_WIDTH-1:0];
      end
      return y;
   endfunction

endpackage

// File: rtl/cplx_conj_mac.sv
// Complex accumulator of x * conj(y) with clear/enable, and a Q-format read-out
// that adds lambda on the diagonal, optionally conjugates and saturates.
module cplx_conj_mac
   import tikhonov_pkg::*;
#(
   parameter int DATA_WIDTH = 24,
   parameter int FRAC_BITS  = 14,
   parameter int LAMBDA     = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a_re,
   input  logic signed [DATA_WIDTH-1:0] a_im,
   input  logic signed [DATA_WIDTH-1:0] c_re,
   input  logic signed [DATA_WIDTH-1:0] c_im,
   input  logic                         diag,
   input  logic                         conj_sel,
   output logic signed [DATA_WIDTH-1:0] g_re,
   output logic signed [DATA_WIDTH-1:0] g_im
);

   localparam logic signed [ACC_WIDTH-1:0] LAMBDA_EXT = ACC_WIDTH'(LAMBDA);

   logic signed [ACC_WIDTH-1:0] ea_re_s, ea_im_s, ec_re_s, ec_im_s;
   logic signed [ACC_WIDTH-1:0] term_re_s, term_im_s;
   logic signed [ACC_WIDTH-1:0] acc_re_r, acc_im_r;
   logic signed [ACC_WIDTH-1:0] sh_re_s, sh_im_s;

   // (a + jb)(c - jd): real ac + bd, imag bc - ad
   always_comb begin
      ea_re_s   = ACC_WIDTH'(a_re);
      ea_im_s   = ACC_WIDTH'(a_im);
      ec_re_s   = ACC_WIDTH'(c_re);
      ec_im_s   = ACC_WIDTH'(c_im);
      term_re_s = ea_re_s * ec_re_s + ea_im_s * ec_im_s;
      term_im_s = ea_im_s * ec_re_s - ea_re_s * ec_im_s;
   end

   // Accumulator; clear together with enable loads the first term directly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_re_r <= {ACC_WIDTH{1'b0}};
         acc_im_r <= {ACC_WIDTH{1'b0}};
      end else if (clr) begin
         acc_re_r <= en ? term_re_s : {ACC_WIDTH{1'b0}};
         acc_im_r <= en ? term_im_s : {ACC_WIDTH{1'b0}};
      end else if (en) begin
         acc_re_r <= acc_re_r + term_re_s;
         acc_im_r <= acc_im_r + term_im_s;
      end else begin
         acc_re_r <= acc_re_r;
         acc_im_r <= acc_im_r;
      end
   end

   // Read-out: truncating shift, then saturate each part independently
   always_comb begin
      sh_re_s = acc_re_r >>> FRAC_BITS;
      sh_im_s = acc_im_r >>> FRAC_BITS;
      if (diag) begin
         g_re = saturate(sh_re_s + LAMBDA_EXT);
         g_im = {DATA_WIDTH{1'b0}};
      end else if (conj_sel) begin
         g_re = saturate(sh_re_s);
         g_im = saturate(-sh_im_s);
      end else begin
         g_re = saturate(sh_re_s);
         g_im = saturate(sh_im_s);
      end
   end

endmodule

// File: rtl/gram_matrix_reg.sv
// Per-bin regularized Gram matrix G = A^H A + lambda*I: loads one bin of A^H into a
// local buffer, accumulates each upper-triangle pair and writes G[i][j] and G[j][i].
module gram_matrix_reg
   import tikhonov_pkg::*;
#(
   parameter int DATA_WIDTH         = 24,
   parameter int FRAC_BITS          = 14,
   parameter int BRAM_RD_ADDR_WIDTH = 10,
   parameter int BRAM_WR_ADDR_WIDTH = 10,
   parameter int BRAM_RD_INCREASE   = 4,
   parameter int BRAM_WR_INCREASE   = 4,
   parameter int LATENCY            = 2,
   parameter int MIC_NUM            = 8,
   parameter int SOR_NUM            = 2,
   parameter int FREQ_NUM           = 257,
   parameter int LAMBDA             = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [DATA_WIDTH-1:0]         bram_rd_real,
   input  logic [DATA_WIDTH-1:0]         bram_rd_imag,
   output logic [BRAM_RD_ADDR_WIDTH-1:0] bram_rd_addr,
   output logic [DATA_WIDTH-1:0]         bram_wr_real,
   output logic [DATA_WIDTH-1:0]         bram_wr_imag,
   output logic [BRAM_WR_ADDR_WIDTH-1:0] bram_wr_addr,
   output logic                          bram_wr_en,
   output logic [3:0]                    bram_wr_we,
   output logic                          busy,
   output logic                          done
);

   localparam int BUF_N    = SOR_NUM * MIC_NUM;
   localparam int LOAD_LEN = BUF_N + LATENCY;
   localparam int CNT_W    = $clog2(LOAD_LEN + 1);
   localparam int BUF_W    = $clog2(BUF_N);
   localparam int SOR_W    = $clog2(SOR_NUM) + 1;
   localparam int F_W      = $clog2(FREQ_NUM) + 1;
   localparam int PAIR_W   = $clog2(PAIR_NUM) + 1;

   state_t                        state_r, next_s;
   logic [CNT_W-1:0]              cnt_r;
   logic [F_W-1:0]                f_r;
   logic [PAIR_W-1:0]             pair_r;
   logic [SOR_W-1:0]              i_r, j_r, row_s, col_s;
   logic [BRAM_RD_ADDR_WIDTH-1:0] rd_addr_r;
   logic signed [DATA_WIDTH-1:0]  buf_re_r [BUF_N];
   logic signed [DATA_WIDTH-1:0]  buf_im_r [BUF_N];
   logic [BUF_W-1:0]              idx_a_s, idx_c_s, cap_idx_s;
   logic                          mac_clr_s, mac_en_s, diag_s, conj_s, wr_cycle_s, last_pair_s;
   logic signed [DATA_WIDTH-1:0]  g_re_s, g_im_s;
   logic [BRAM_WR_ADDR_WIDTH-1:0] wr_addr_s, wr_addr_r;
   logic [DATA_WIDTH-1:0]         wr_real_r, wr_imag_r;
   logic                          wr_en_r, busy_r, done_r;
   logic [3:0]                    wr_we_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_s      = state_r;
      last_pair_s = (pair_r == PAIR_W'(PAIR_NUM - 1));
      case (state_r)
         S_IDLE: if (start) next_s = S_LOAD; else next_s = S_IDLE;
         S_LOAD: if (cnt_r == CNT_W'(LOAD_LEN - 1)) next_s = S_MAC; else next_s = S_LOAD;
         S_MAC:  if (cnt_r == CNT_W'(MIC_NUM - 1)) next_s = S_WR; else next_s = S_MAC;
         S_WR: begin
            if (i_r != j_r)       next_s = S_WRT;
            else if (last_pair_s) next_s = S_NEXT;
            else                  next_s = S_MAC;
         end
         S_WRT:  if (last_pair_s) next_s = S_NEXT; else next_s = S_MAC;
         S_NEXT: if (f_r == F_W'(FREQ_NUM - 1)) next_s = S_DONE; else next_s = S_LOAD;
         S_DONE: next_s = S_IDLE;
         default: next_s = S_IDLE;
      endcase
   end

   // Buffer indexing, MAC control and write-address formation
   always_comb begin
      idx_a_s    = BUF_W'(int'(i_r) * MIC_NUM + int'(cnt_r));
      idx_c_s    = BUF_W'(int'(j_r) * MIC_NUM + int'(cnt_r));
      cap_idx_s  = BUF_W'(int'(cnt_r) - LATENCY);
      mac_en_s   = (state_r == S_MAC);
      mac_clr_s  = mac_en_s && (cnt_r == CNT_W'(0));
      diag_s     = (i_r == j_r);
      conj_s     = (state_r == S_WRT);
      wr_cycle_s = (state_r == S_WR) || conj_s;
      if (conj_s) begin
         row_s = j_r;
         col_s = i_r;
      end else begin
         row_s = i_r;
         col_s = j_r;
      end
      wr_addr_s = BRAM_WR_ADDR_WIDTH'(((int'(f_r) * SOR_NUM + int'(row_s)) * SOR_NUM
                                       + int'(col_s)) * BRAM_WR_INCREASE);
   end

   // Phase counter, bin/pair indices and read address sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= CNT_W'(0);
         f_r       <= F_W'(0);
         pair_r    <= PAIR_W'(0);
         i_r       <= SOR_W'(0);
         j_r       <= SOR_W'(0);
         rd_addr_r <= BRAM_RD_ADDR_WIDTH'(0);
      end else begin
         if (next_s != state_r || state_r == S_IDLE) cnt_r <= CNT_W'(0);
         else                                         cnt_r <= cnt_r + CNT_W'(1);
         case (state_r)
            S_IDLE: begin
               f_r       <= F_W'(0);
               pair_r    <= PAIR_W'(0);
               i_r       <= SOR_W'(0);
               j_r       <= SOR_W'(0);
               rd_addr_r <= BRAM_RD_ADDR_WIDTH'(0);
            end
            S_LOAD: begin
               if (cnt_r < CNT_W'(BUF_N))
                  rd_addr_r <= rd_addr_r + BRAM_RD_ADDR_WIDTH'(BRAM_RD_INCREASE);
            end
            S_WR, S_WRT: begin
               if (next_s == S_MAC) begin
                  pair_r <= pair_r + PAIR_W'(1);
                  if (j_r == SOR_W'(SOR_NUM - 1)) begin
                     i_r <= i_r + SOR_W'(1);
                     j_r <= i_r + SOR_W'(1);
                  end else begin
                     j_r <= j_r + SOR_W'(1);
                  end
               end
            end
            S_NEXT: begin
               f_r    <= f_r + F_W'(1);
               pair_r <= PAIR_W'(0);
               i_r    <= SOR_W'(0);
               j_r    <= SOR_W'(0);
            end
            default: begin
               f_r <= f_r;
            end
         endcase
      end
   end

   // Capture read data LATENCY cycles after each address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BUF_N; k++) begin
            buf_re_r[k] <= {DATA_WIDTH{1'b0}};
            buf_im_r[k] <= {DATA_WIDTH{1'b0}};
         end
      end else if (state_r == S_LOAD && cnt_r >= CNT_W'(LATENCY)) begin
         buf_re_r[cap_idx_s] <= $signed(bram_rd_real);
         buf_im_r[cap_idx_s] <= $signed(bram_rd_imag);
      end
   end

   cplx_conj_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .LAMBDA     (LAMBDA)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (mac_clr_s),
      .en       (mac_en_s),
      .a_re     (buf_re_r[idx_a_s]),
      .a_im     (buf_im_r[idx_a_s]),
      .c_re     (buf_re_r[idx_c_s]),
      .c_im     (buf_im_r[idx_c_s]),
      .diag     (diag_s),
      .conj_sel (conj_s),
      .g_re     (g_re_s),
      .g_im     (g_im_s)
   );

   // Registered write port and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_real_r <= {DATA_WIDTH{1'b0}};
         wr_imag_r <= {DATA_WIDTH{1'b0}};
         wr_addr_r <= BRAM_WR_ADDR_WIDTH'(0);
         wr_en_r   <= 1'b0;
         wr_we_r   <= 4'b0000;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         if (wr_cycle_s) begin
            wr_real_r <= g_re_s;
            wr_imag_r <= g_im_s;
            wr_addr_r <= wr_addr_s;
            wr_en_r   <= 1'b1;
            wr_we_r   <= 4'b1111;
         end else begin
            wr_en_r   <= 1'b0;
            wr_we_r   <= 4'b0000;
         end
         busy_r <= (next_s != S_IDLE) && (next_s != S_DONE);
         done_r <= (next_s == S_DONE);
      end
   end

   assign bram_rd_addr = rd_addr_r;
   assign bram_wr_real = wr_real_r;
   assign bram_wr_imag = wr_imag_r;
   assign bram_wr_addr = wr_addr_r;
   assign bram_wr_en   = wr_en_r;
   assign bram_wr_we   = wr_we_r;
   assign busy         = busy_r;
   assign done         = done_r;

endmodule
